// File: rtl/multicycle_ctrl_if.sv
// Control-side bundle between the multicycle sequencer and the datapath/memory.
// The master is the sequencer. The slave is the datapath, memory or testbench side.
interface multicycle_ctrl_if #(parameter int CNT_W = 16);
  logic             run;
  logic [31:0]      instr;
  logic             zero;
  logic             mem_ready;
  logic [1:0]       alu_op;
  logic [3:0]       alu_opcode;
  logic             alu_src_imm;
  logic             ext_zero;
  logic             ir_write;
  logic             pc_write;
  logic             pc_src;
  logic             reg_write;
  logic             wb_src;
  logic             mem_read;
  logic             mem_write;
  logic             inst_fetch;
  logic             addr_latch;
  logic             illegal;
  logic             bus_err;
  logic             halted;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  run, instr, zero, mem_ready,
    output alu_op, alu_opcode, alu_src_imm, ext_zero, ir_write, pc_write, pc_src,
           reg_write, wb_src, mem_read, mem_write, inst_fetch, addr_latch,
           illegal, bus_err, halted, instr_count
  );

  modport slave (
    output run, instr, zero, mem_ready,
    input  alu_op, alu_opcode, alu_src_imm, ext_zero, ir_write, pc_write, pc_src,
           reg_write, wb_src, mem_read, mem_write, inst_fetch, addr_latch,
           illegal, bus_err, halted, instr_count
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the 32-bit datapath. It runs fetch, decode, execute,
// memory and writeback, and it times out memory waits that never complete.
//   state    | meaning
//   IDLE     | waiting for run          FETCH    | instruction read, IR/PC load
//   DECODE   | classify instr           EXEC     | ALU op for R/I/LI
//   WB       | ALU result to regfile    BRANCH   | compare, optional PC load
//   MEM_ADDR | address compute/latch    MEM_RD   | load wait
//   MEM_WB   | load data to regfile     MEM_WR   | store wait
//   HALTED   | stopped until reset
module multicycle_ctrl #(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  multicycle_ctrl_if.master io_bus
);
  localparam int WAIT_W = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_MAX - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_BRANCH,
    S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_HALTED
  } state_t;

  state_t            r_state, w_next;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_count;
  logic              r_bus_err;

  logic [1:0] w_fmt;
  logic [3:0] w_opc;
  logic w_is_arith, w_is_br, w_is_li, w_is_lwi, w_is_swi, w_is_halt;
  logic w_alu_imm, w_ext_zero, w_taken;
  logic w_waiting, w_timeout, w_retire, w_err, w_unused;

  assign w_fmt      = io_bus.instr[31:30];
  assign w_opc      = io_bus.instr[29:26];
  assign w_unused   = ^io_bus.instr[25:0];
  assign w_is_arith = (w_fmt == 2'b00 || w_fmt == 2'b01) && !w_opc[3];
  assign w_is_br    = (w_fmt == 2'b10) && (w_opc[3:1] == 3'b000);
  assign w_is_li    = (w_fmt == 2'b11) && (w_opc == 4'b1001);
  assign w_is_lwi   = (w_fmt == 2'b11) && (w_opc == 4'b1011);
  assign w_is_swi   = (w_fmt == 2'b11) && (w_opc == 4'b1100);
  assign w_is_halt  = (w_fmt == 2'b11) && (w_opc == 4'b1111);
  assign w_alu_imm  = (w_fmt == 2'b01) || w_is_li;
  assign w_ext_zero = (w_opc == 4'b0100) || (w_opc == 4'b0101) || (w_opc == 4'b0110);
  assign w_taken    = (w_opc == 4'b0000 && io_bus.zero) || (w_opc == 4'b0001 && !io_bus.zero);

  assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  // r_wait counts down the misses still allowed, so 0 means this is the last one
  assign w_timeout = w_waiting && !io_bus.mem_ready && (r_wait == '0);

  assign io_bus.bus_err     = r_bus_err;
  assign io_bus.halted      = (r_state == S_HALTED);
  assign io_bus.instr_count = r_count;

  always_comb begin
    w_next             = r_state;
    w_retire           = 1'b0;
    w_err              = 1'b0;
    io_bus.alu_op      = 2'b00;
    io_bus.alu_opcode  = 4'b0000;
    io_bus.alu_src_imm = 1'b0;
    io_bus.ext_zero    = 1'b0;
    io_bus.ir_write    = 1'b0;
    io_bus.pc_write    = 1'b0;
    io_bus.pc_src      = 1'b0;
    io_bus.reg_write   = 1'b0;
    io_bus.wb_src      = 1'b0;
    io_bus.mem_read    = 1'b0;
    io_bus.mem_write   = 1'b0;
    io_bus.inst_fetch  = 1'b0;
    io_bus.addr_latch  = 1'b0;
    io_bus.illegal     = 1'b0;
    case (r_state)
      S_IDLE: if (io_bus.run) w_next = S_FETCH;
      S_FETCH: begin
        io_bus.mem_read   = 1'b1;
        io_bus.inst_fetch = 1'b1;
        if (io_bus.mem_ready) begin
          io_bus.ir_write = 1'b1;
          io_bus.pc_write = 1'b1;
          w_next          = S_DECODE;
        end else if (w_timeout) begin
          w_err  = 1'b1;
          w_next = S_HALTED;
        end
      end
      S_DECODE: begin
        if (w_is_arith || w_is_li)      w_next = S_EXEC;
        else if (w_is_br)               w_next = S_BRANCH;
        else if (w_is_lwi || w_is_swi)  w_next = S_MEM_ADDR;
        else if (w_is_halt)             w_next = S_HALTED;
        else begin
          io_bus.illegal = 1'b1;
          w_retire       = 1'b1;
          w_next         = S_FETCH;
        end
      end
      S_EXEC, S_WB: begin
        io_bus.alu_op      = 2'b01;
        io_bus.alu_opcode  = w_opc;
        io_bus.alu_src_imm = w_alu_imm;
        io_bus.ext_zero    = w_ext_zero;
        if (r_state == S_EXEC) w_next = S_WB;
        else begin
          io_bus.reg_write = 1'b1;
          w_retire         = 1'b1;
          w_next           = S_FETCH;
        end
      end
      S_BRANCH: begin
        io_bus.alu_op   = 2'b10;
        io_bus.pc_write = w_taken;
        io_bus.pc_src   = w_taken;
        w_retire        = 1'b1;
        w_next          = S_FETCH;
      end
      S_MEM_ADDR: begin
        io_bus.alu_op      = 2'b11;
        io_bus.alu_opcode  = w_opc;
        io_bus.alu_src_imm = 1'b1;
        io_bus.ext_zero    = 1'b1;
        io_bus.addr_latch  = 1'b1;
        w_next             = w_is_lwi ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        io_bus.mem_read = 1'b1;
        if (io_bus.mem_ready) w_next = S_MEM_WB;
        else if (w_timeout) begin
          w_err  = 1'b1;
          w_next = S_HALTED;
        end
      end
      S_MEM_WB: begin
        io_bus.reg_write = 1'b1;
        io_bus.wb_src    = 1'b1;
        w_retire         = 1'b1;
        w_next           = S_FETCH;
      end
      S_MEM_WR: begin
        // ALU passes R2 through as store data while the write is pending
        io_bus.alu_op     = 2'b01;
        io_bus.alu_opcode = 4'b1100;
        io_bus.mem_write  = 1'b1;
        if (io_bus.mem_ready) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else if (w_timeout) begin
          w_err  = 1'b1;
          w_next = S_HALTED;
        end
      end
      S_HALTED: w_next = S_HALTED;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_count   <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((w_next != r_state) &&
          (w_next == S_FETCH || w_next == S_MEM_RD || w_next == S_MEM_WR))
        r_wait <= WAIT_LOAD;
      else if (w_waiting && !io_bus.mem_ready && (r_wait != '0))
        r_wait <= r_wait - 1'b1;
      if (w_retire) r_count <= r_count + 1'b1;
      if (w_err) r_bus_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Each step drives inputs 1 ns after the rising edge
// and checks outputs on the falling edge against hand-computed values.
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(16)) bus ();
  multicycle_ctrl_if #(.CNT_W(3))  bus_s ();

  multicycle_ctrl #(.CNT_W(16), .WAIT_MAX(8)) dut   (.i_clk(clk), .i_rst(rst), .io_bus(bus));
  multicycle_ctrl #(.CNT_W(3),  .WAIT_MAX(8)) dut_s (.i_clk(clk), .i_rst(rst), .io_bus(bus_s));

  localparam logic [31:0] I_R_ADD = {2'b00, 4'b0010, 26'd0};
  localparam logic [31:0] I_ANDI  = {2'b01, 4'b0101, 26'd0};
  localparam logic [31:0] I_ADDI  = {2'b01, 4'b0010, 26'd0};
  localparam logic [31:0] I_BEQ   = {2'b10, 4'b0000, 26'd0};
  localparam logic [31:0] I_BNE   = {2'b10, 4'b0001, 26'd0};
  localparam logic [31:0] I_ILL   = {2'b10, 4'b0111, 26'd0};
  localparam logic [31:0] I_LI    = {2'b11, 4'b1001, 26'd0};
  localparam logic [31:0] I_LWI   = {2'b11, 4'b1011, 26'd0};
  localparam logic [31:0] I_SWI   = {2'b11, 4'b1100, 26'd0};
  localparam logic [31:0] I_HALT  = {2'b11, 4'b1111, 26'd0};

  // strobe bit positions, matching the packing in obs_main()
  localparam logic [11:0] IRW = 12'h800, PCW = 12'h400, PCS = 12'h200, RGW = 12'h100;
  localparam logic [11:0] WBS = 12'h080, MRD = 12'h040, MWR = 12'h020, IFE = 12'h010;
  localparam logic [11:0] ADL = 12'h008, ILL = 12'h004, BER = 12'h002, HLT = 12'h001;
  localparam logic [11:0] F_OK = IRW | PCW | MRD | IFE;

  function automatic logic [19:0] obs_main();
    return {bus.alu_op, bus.alu_opcode, bus.alu_src_imm, bus.ext_zero,
            bus.ir_write, bus.pc_write, bus.pc_src, bus.reg_write, bus.wb_src,
            bus.mem_read, bus.mem_write, bus.inst_fetch, bus.addr_latch,
            bus.illegal, bus.bus_err, bus.halted};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] alu, input logic [11:0] strb);
    chk(tag, {12'd0, obs_main()}, {12'd0, alu, strb});
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] exp);
    chk(tag, {16'd0, bus.instr_count}, {16'd0, exp});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    bus.run = 1'b0;   bus.instr = '0;   bus.zero = 1'b0;   bus.mem_ready = 1'b0;
    bus_s.run = 1'b0; bus_s.instr = '0; bus_s.zero = 1'b0; bus_s.mem_ready = 1'b0;

    cyc(); cyc(); settle();
    chk_out("reset_outs", 8'h00, 12'h000);
    chk_cnt("reset_count", 16'd0);

    // R-type ADD, mem_ready tied high
    cyc(); rst = 1'b0; bus.run = 1'b1; bus.instr = I_R_ADD; bus.mem_ready = 1'b1;
    settle(); chk_out("idle", 8'h00, 12'h000);
    cyc(); bus.run = 1'b0; settle(); chk_out("r_fetch", 8'h00, F_OK);
    cyc(); settle(); chk_out("r_decode", 8'h00, 12'h000);
    cyc(); settle(); chk_out("r_exec", 8'b01_0010_0_0, 12'h000);
    cyc(); settle(); chk_out("r_wb", 8'b01_0010_0_0, RGW);
    cyc(); bus.instr = I_ANDI; settle(); chk_cnt("r_count", 16'd1);

    // ANDI zero-extends, ADDI sign-extends
    cyc(); cyc(); settle(); chk_out("andi_exec", 8'b01_0101_1_1, 12'h000);
    cyc(); settle(); chk_out("andi_wb", 8'b01_0101_1_1, RGW);
    cyc(); bus.instr = I_ADDI;
    cyc(); cyc(); settle(); chk_out("addi_exec", 8'b01_0010_1_0, 12'h000);
    cyc(); cyc(); bus.instr = I_BNE; bus.zero = 1'b0; settle(); chk_cnt("addi_count", 16'd3);

    // branches: 3 cycles each
    cyc(); cyc(); settle(); chk_out("bne_taken", 8'b10_0000_0_0, PCW | PCS);
    cyc(); bus.zero = 1'b1; settle(); chk_cnt("bne_t_count", 16'd4);
    cyc(); cyc(); settle(); chk_out("bne_not", 8'b10_0000_0_0, 12'h000);
    cyc(); bus.instr = I_BEQ; settle(); chk_cnt("bne_n_count", 16'd5);
    cyc(); cyc(); settle(); chk_out("beq_taken", 8'b10_0000_0_0, PCW | PCS);
    cyc(); bus.instr = I_SWI; bus.zero = 1'b0; settle(); chk_cnt("beq_count", 16'd6);

    // SWI with three not-ready cycles in MEM_WR
    cyc(); bus.mem_ready = 1'b0;
    cyc(); settle(); chk_out("swi_addr", 8'b11_1100_1_1, ADL);
    cyc(); settle(); chk_out("swi_wr1", 8'b01_1100_0_0, MWR);
    cyc(); settle(); chk_out("swi_wr2", 8'b01_1100_0_0, MWR);
    cyc(); settle(); chk_out("swi_wr3", 8'b01_1100_0_0, MWR);
    cyc(); bus.mem_ready = 1'b1; settle(); chk_out("swi_wr4", 8'b01_1100_0_0, MWR);
    chk_cnt("swi_pending_count", 16'd6);
    cyc(); bus.instr = I_LWI; settle(); chk_out("swi_next_fetch", 8'h00, F_OK);
    chk_cnt("swi_count", 16'd7);

    // LWI
    cyc(); cyc(); settle(); chk_out("lwi_addr", 8'b11_1011_1_1, ADL);
    cyc(); settle(); chk_out("lwi_rd", 8'h00, MRD);
    cyc(); settle(); chk_out("lwi_wb", 8'h00, RGW | WBS);
    cyc(); bus.instr = I_ILL; settle(); chk_cnt("lwi_count", 16'd8);

    // undefined instruction: one-cycle illegal pulse, retires as NOP
    cyc(); settle(); chk_out("ill_decode", 8'h00, ILL);
    cyc(); bus.instr = I_LI; settle(); chk_out("ill_after", 8'h00, F_OK);
    chk_cnt("ill_count", 16'd9);

    // LI uses the immediate, sign-extended
    cyc(); cyc(); settle(); chk_out("li_exec", 8'b01_1001_1_0, 12'h000);
    cyc(); cyc(); bus.instr = I_LWI; settle(); chk_cnt("li_count", 16'd10);

    // reset while waiting in MEM_RD
    cyc(); cyc(); cyc(); bus.mem_ready = 1'b0; rst = 1'b1;
    settle(); chk_out("rst_in_memrd", 8'h00, MRD);
    cyc(); rst = 1'b0; bus.run = 1'b1; bus.instr = I_HALT; bus.mem_ready = 1'b1;
    settle(); chk_out("rst_idle_outs", 8'h00, 12'h000);
    chk_cnt("rst_idle_count", 16'd0);

    // HALT instruction: stops without retiring
    cyc(); bus.run = 1'b0; cyc(); cyc(); settle();
    chk_out("halt_instr", 8'h00, HLT);
    chk_cnt("halt_count", 16'd0);

    // fetch timeout after WAIT_MAX misses
    rst = 1'b1; cyc(); rst = 1'b0; bus.run = 1'b1; bus.mem_ready = 1'b0;
    settle(); chk_out("to_idle", 8'h00, 12'h000);
    cyc(); bus.run = 1'b0; settle(); chk_out("to_fetch1", 8'h00, MRD | IFE);
    repeat (7) cyc();
    settle(); chk_out("to_fetch8", 8'h00, MRD | IFE);
    cyc(); settle(); chk_out("to_halted", 8'h00, HLT | BER);
    cyc(); bus.run = 1'b1; bus.mem_ready = 1'b1;
    cyc(); settle(); chk_out("halt_ignores_run", 8'h00, HLT | BER);
    chk_cnt("to_count", 16'd0);
    rst = 1'b1; bus.run = 1'b0; cyc(); rst = 1'b0;
    settle(); chk_out("to_rst_clear", 8'h00, 12'h000);

    // counter wrap on the 3-bit instance
    bus_s.instr = I_R_ADD; bus_s.mem_ready = 1'b1; bus_s.run = 1'b1;
    cyc(); bus_s.run = 1'b0;
    repeat (28) cyc();
    settle(); chk("wrap_pre", {29'd0, bus_s.instr_count}, 32'd7);
    repeat (4) cyc();
    settle(); chk("wrap_zero", {29'd0, bus_s.instr_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
